// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array output drain.
// Contents: FP16 field constants, drain FSM state type and the result-index width helper.
package systolic_pkg;

   localparam int unsigned EXP_W    = 5;
   localparam int unsigned MANT_W   = 10;
   localparam int unsigned EXP_BIAS = 15;
   localparam logic [15:0] FP16_INF = 16'h7C00;

   typedef enum logic {
      IDLE,
      SEND
   } drain_state_e;

   // Width needed to index n*n results; never below one bit.
   function automatic int unsigned calc_idx_w(input int unsigned n);
      return (n * n > 1) ? unsigned'($clog2(n * n)) : 1;
   endfunction

endpackage

// File: rtl/systolic_drain_if.sv
// Valid/ready result stream leaving the systolic drain.
// Signals: out_valid/out_data/out_idx/out_last (producer to consumer), out_ready (consumer to
// producer).
// Modports: master = drain side, slave = consumer side.
interface systolic_drain_if #(
   parameter int unsigned IDX_W = 2
) ();

   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_data;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_idx,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_idx,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/fp16_from_fixed.sv
// Combinational conversion of one accumulator entry (two's-complement fixed point with
// FRAC_BITS fraction bits at exponent bias, plus a 5-bit exponent) to IEEE FP16 with
// round-to-nearest-even.
// Ports: acc_i (accumulator), exp_i (exponent), fp16_o (result).
// Build option: SYSTOLIC_DRAIN_SUBNORM_EN produces FP16 subnormals for tiny results;
// otherwise they are flushed to signed zero.
module fp16_from_fixed
   import systolic_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = 32,
   parameter int unsigned FRAC_BITS = 10
) (
   input  logic [ACC_WIDTH-1:0] acc_i,
   input  logic [EXP_W-1:0]     exp_i,
   output logic [15:0]          fp16_o
);

   localparam int unsigned W = ACC_WIDTH;

   logic              sign;
   logic [W-1:0]      mag;
   logic [W-2:0]      frac;    // bits below the leading one, left-aligned
   int unsigned       lead;
   logic signed [7:0] e_pre;
   logic signed [7:0] e_fin;
   logic [MANT_W-1:0] mant;
   logic              guard;
   logic              sticky;
   logic              rnd;
   logic [MANT_W:0]   mant_r;
`ifdef SYSTOLIC_DRAIN_SUBNORM_EN
   logic [3:0]          sub_amt;
   logic [W+MANT_W-1:0] sub_sh;
   logic                sub_rnd;
   logic [MANT_W:0]     sub_r;
`endif

   always_comb begin
      sign = acc_i[W-1];
      // 0x80..0 negates to itself, which reads correctly as an unsigned 2^(W-1).
      mag  = sign ? (~acc_i + 1'b1) : acc_i;

      lead = 0;
      for (int unsigned i = 0; i < W; i++) begin
         if (mag[i]) lead = i;
      end
      frac = (W-1)'(mag << (W - 1 - lead));

      e_pre = 8'(lead) + 8'(exp_i) - 8'(FRAC_BITS);

      mant   = frac[W-2 -: MANT_W];
      guard  = frac[W-2-MANT_W];
      sticky = |frac[W-3-MANT_W:0];
      rnd    = guard & (sticky | mant[0]);
      mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, rnd};
      // Mantissa overflow leaves the low bits zero and bumps the exponent.
      e_fin  = e_pre + (mant_r[MANT_W] ? 8'sd1 : 8'sd0);

`ifdef SYSTOLIC_DRAIN_SUBNORM_EN
      // Subnormal significand = 1.frac scaled by 2^(e_pre+9): shift right by -e_pre from
      // the 10-bit window. A result of 1024 spills into exponent field 1.
      sub_amt = (e_pre < 8'sd0) ? 4'(-e_pre) : 4'd0;
      sub_sh  = {1'b1, frac, {MANT_W{1'b0}}} >> sub_amt;
      sub_rnd = sub_sh[W-1] & ((|sub_sh[W-2:0]) | sub_sh[W]);
      sub_r   = {1'b0, sub_sh[W+MANT_W-1:W]} + {{MANT_W{1'b0}}, sub_rnd};
`endif

      if (mag == '0) begin
         fp16_o = 16'h0000;
`ifdef SYSTOLIC_DRAIN_SUBNORM_EN
      end else if (e_pre <= 8'sd0) begin
         fp16_o = {sign, 4'b0000, sub_r};
`endif
      end else if (e_fin >= 8'sd31) begin
         fp16_o = {sign, 15'b0} | FP16_INF;
      end else if (e_fin <= 8'sd0) begin
         fp16_o = {sign, 15'b0};
      end else begin
         fp16_o = {sign, e_fin[EXP_W-1:0], mant_r[MANT_W-1:0]};
      end
   end

endmodule

// File: rtl/systolic_drain.sv
// Output drain for the FP-INT systolic array. A done pulse snapshots all N*N accumulators
// and exponents; entries are then converted to FP16 and streamed row-major, one per cycle
// under ready, with a registered output stage.
// Ports: clk, rst (async, active high), done (capture request), acc_in/exp_in (flattened
// per-PE results, entry i = row*N+col), out_if (result stream, master side), busy
// (snapshot held), missed (sticky: done arrived while busy).
// Build option: SYSTOLIC_DRAIN_SUBNORM_EN enables FP16 subnormal outputs in the converter.
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int unsigned N         = 2,
   parameter int unsigned ACC_WIDTH = 32,
   parameter int unsigned FRAC_BITS = 10,
   parameter int unsigned IDX_W     = calc_idx_w(N)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       done,
   input  logic [N*N*ACC_WIDTH-1:0]   acc_in,
   input  logic [N*N*EXP_W-1:0]       exp_in,
   systolic_drain_if.master           out_if,
   output logic                       busy,
   output logic                       missed
);

   localparam int unsigned      NumEnt  = N * N;
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NumEnt - 1);

   drain_state_e               state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic                       valid_q, valid_d;
   logic [15:0]                data_q, data_d;
   logic                       last_q, last_d;
   logic                       missed_q, missed_d;
   logic [NumEnt*ACC_WIDTH-1:0] snap_acc_q;
   logic [NumEnt*EXP_W-1:0]     snap_exp_q;

   logic                 capture;
   logic                 xfer;
   logic                 at_last;
   logic [IDX_W-1:0]     idx_inc;
   logic [IDX_W-1:0]     sel;
   logic [ACC_WIDTH-1:0] conv_acc;
   logic [EXP_W-1:0]     conv_exp;
   logic [15:0]          conv_data;

   // The converter always looks at the entry that would be registered at the coming edge:
   // the current index while loading, the following one while presenting.
   always_comb begin
      at_last  = (idx_q == LastIdx);
      idx_inc  = idx_q + 1'b1;
      sel      = (valid_q && !at_last) ? idx_inc : idx_q;
      conv_acc = snap_acc_q[sel*ACC_WIDTH +: ACC_WIDTH];
      conv_exp = snap_exp_q[sel*EXP_W +: EXP_W];
   end

   fp16_from_fixed #(
      .ACC_WIDTH(ACC_WIDTH),
      .FRAC_BITS(FRAC_BITS)
   ) u_conv (
      .acc_i (conv_acc),
      .exp_i (conv_exp),
      .fp16_o(conv_data)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      data_d   = data_q;
      last_d   = last_q;
      missed_d = missed_q;
      capture  = 1'b0;
      xfer     = valid_q & out_if.out_ready;

      unique case (state_q)
         IDLE: begin
            if (done) begin
               capture = 1'b1;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (!valid_q) begin
               valid_d = 1'b1;
               data_d  = conv_data;
               last_d  = at_last;
            end else if (xfer) begin
               if (at_last) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  // A done coinciding with the final transfer starts the next drain.
                  if (done) begin
                     capture = 1'b1;
                     idx_d   = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d  = idx_inc;
                  data_d = conv_data;
                  last_d = (idx_inc == LastIdx);
               end
            end
            if (done && !(xfer && at_last)) missed_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         last_q     <= 1'b0;
         missed_q   <= 1'b0;
         snap_acc_q <= '0;
         snap_exp_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         last_q   <= last_d;
         missed_q <= missed_d;
         if (capture) begin
            snap_acc_q <= acc_in;
            snap_exp_q <= exp_in;
         end
      end
   end

   assign out_if.out_valid = valid_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_idx   = idx_q;
   assign out_if.out_last  = last_q;
   assign busy             = (state_q == SEND);
   assign missed           = missed_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain: directed vectors plus randomized drains checked
// against an arithmetic FP16 reference model and a transfer scoreboard.
module tb_systolic_drain;
   import systolic_pkg::*;

   localparam int unsigned N  = 2;
   localparam int unsigned NE = N * N;
   localparam int unsigned AW = 32;
   localparam int unsigned IW = calc_idx_w(N);

   logic                clk = 1'b0;
   logic                rst;
   logic                done;
   logic [NE*AW-1:0]    acc_in;
   logic [NE*EXP_W-1:0] exp_in;
   logic                busy;
   logic                missed;

   systolic_drain_if #(.IDX_W(IW)) out_if ();

   systolic_drain #(
      .N(N),
      .ACC_WIDTH(AW),
      .FRAC_BITS(10),
      .IDX_W(IW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .done  (done),
      .acc_in(acc_in),
      .exp_in(exp_in),
      .out_if(out_if),
      .busy  (busy),
      .missed(missed)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] acc_v  [NE];
   logic [4:0]  exp_v  [NE];
   logic [15:0] want_v [NE];
   logic [15:0] exp_data_q [$];
   int          exp_idx_q  [$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      if (obs === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, req);
   endtask

   // Value = a * 2^(e-25); FP16 built from the magnitude with integer RNE.
   function automatic logic [15:0] fp16_model(input logic [31:0] a, input logic [4:0] e);
      bit               s;
      longint unsigned  mag, q, rem, half, q2;
      int               p, ee, sh;
      s   = a[31];
      mag = s ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
      if (mag == 0) return 16'h0000;
      p = 0;
      for (int i = 0; i < 32; i++) if (((mag >> i) & 1) == 1) p = i;
      ee = p + int'(e) - 10;
`ifdef SYSTOLIC_DRAIN_SUBNORM_EN
      if (ee <= 0) begin
         // Units of the smallest subnormal 2^-24: mag * 2^(e-1).
         if (e >= 1) q2 = mag << (int'(e) - 1);
         else begin
            q2 = mag >> 1;
            if ((mag & 1) == 1 && (q2 & 1) == 1) q2 = q2 + 1;
         end
         return {s, 15'(q2)};
      end
`endif
      if (p > 10) begin
         sh   = p - 10;
         q    = mag >> sh;
         rem  = mag - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
      end else begin
         q = mag << (10 - p);
      end
      if (q == 2048) begin
         q  = 1024;
         ee = ee + 1;
      end
      if (ee >= 31) return {s, 15'h7C00};
      if (ee <= 0) return {s, 15'h0000};
      return {s, 5'(ee), 10'(q - 1024)};
   endfunction

   function automatic logic [31:0] rand_acc();
      case ($urandom_range(5))
         0: return 32'($urandom);
         1: return 32'($urandom_range(4095));
         2: return 32'(0) - 32'($urandom_range(4095));
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(3));
         default: return 32'h0;
      endcase
   endfunction

   task automatic apply_inputs();
      for (int i = 0; i < NE; i++) begin
         acc_in[i*AW +: AW]       = acc_v[i];
         exp_in[i*EXP_W +: EXP_W] = exp_v[i];
      end
   endtask

   task automatic model_want();
      for (int i = 0; i < NE; i++) want_v[i] = fp16_model(acc_v[i], exp_v[i]);
   endtask

   task automatic randomize_load();
      for (int i = 0; i < NE; i++) begin
         acc_v[i] = rand_acc();
         exp_v[i] = 5'($urandom_range(31));
      end
      model_want();
   endtask

   task automatic push_want();
      for (int i = 0; i < NE; i++) begin
         exp_data_q.push_back(want_v[i]);
         exp_idx_q.push_back(i);
      end
   endtask

   // Capture edge, then the load edge: element 0 visible one cycle after done.
   task automatic fire();
      apply_inputs();
      push_want();
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      check_eq("cap_busy", 32'(busy), 32'd1);
      check_eq("cap_valid", 32'(out_if.out_valid), 32'd0);
      @(posedge clk); #1;
      check_eq("lat_valid", 32'(out_if.out_valid), 32'd1);
      check_eq("lat_idx", 32'(out_if.out_idx), 32'd0);
   endtask

   task automatic drain(input int ready_pct, input int stall_idx, input bit poke, input bit b2b,
                        output int cycles);
      int          budget = 200;
      int          stalls = 0;
      bit          poked  = 0;
      bit          b2b_now;
      bit          hold   = 0;
      logic [15:0] pd     = '0;
      logic [IW-1:0] pi   = '0;
      int          idx_e;
      cycles = 0;
      while (exp_data_q.size() > 0 && budget > 0) begin
         budget--;
         cycles++;
         b2b_now = 0;
         if (hold) begin
            check_eq("hold_data", 32'(out_if.out_data), 32'(pd));
            check_eq("hold_idx", 32'(out_if.out_idx), 32'(pi));
         end
         if (out_if.out_valid && stall_idx == int'(out_if.out_idx) && stalls < 3) begin
            out_if.out_ready = 1'b0;
            stalls++;
         end else begin
            out_if.out_ready = ($urandom_range(99) < ready_pct);
         end
         if (b2b && out_if.out_valid && out_if.out_last) begin
            out_if.out_ready = 1'b1;
            randomize_load();
            apply_inputs();
            done    = 1'b1;
            b2b_now = 1;
            b2b     = 0;
         end
         if (poke && !poked && out_if.out_valid && out_if.out_idx == IW'(2)) begin
            acc_in = ~acc_in;
            done   = 1'b1;
            poked  = 1;
         end
         hold = out_if.out_valid && !out_if.out_ready;
         pd   = out_if.out_data;
         pi   = out_if.out_idx;
         if (out_if.out_valid && out_if.out_ready) begin
            check_eq("xfer_data", 32'(out_if.out_data), 32'(exp_data_q.pop_front()));
            idx_e = exp_idx_q.pop_front();
            check_eq("xfer_idx", 32'(out_if.out_idx), 32'(idx_e));
            check_eq("xfer_last", 32'(out_if.out_last), 32'(idx_e == NE - 1));
         end
         @(posedge clk); #1;
         done = 1'b0;
         if (b2b_now) begin
            push_want();
            check_eq("b2b_busy", 32'(busy), 32'd1);
            check_eq("b2b_gap_valid", 32'(out_if.out_valid), 32'd0);
            @(posedge clk); #1;
            check_eq("b2b_valid", 32'(out_if.out_valid), 32'd1);
            check_eq("b2b_idx", 32'(out_if.out_idx), 32'd0);
         end
      end
      check_eq("drain_left", 32'(exp_data_q.size()), 32'd0);
      exp_data_q.delete();
      exp_idx_q.delete();
      check_eq("end_valid", 32'(out_if.out_valid), 32'd0);
      check_eq("end_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      rst              = 1'b1;
      done             = 1'b0;
      acc_in           = '0;
      exp_in           = '0;
      out_if.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(out_if.out_valid), 32'd0);
      check_eq("rst_data", 32'(out_if.out_data), 32'd0);
      check_eq("rst_idx", 32'(out_if.out_idx), 32'd0);
      check_eq("rst_last", 32'(out_if.out_last), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_missed", 32'(missed), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Full-rate drain of a known load.
      acc_v  = '{32'hFFFF9000, 32'hFFFF9000, 32'hFFFFAC00, 32'hFFFFAC00};
      exp_v  = '{5'd15, 5'd15, 5'd15, 5'd15};
      want_v = '{16'hCF00, 16'hCF00, 16'hCD40, 16'hCD40};
      fire();
      drain(100, -1, 0, 0, cyc);
      check_eq("t1_cycles", 32'(cyc), 32'd4);

      // Same load, consumer stalls three cycles on index 1.
      fire();
      drain(100, 1, 0, 0, cyc);
      check_eq("t2_cycles", 32'(cyc), 32'd7);

      // Directed conversion values.
      acc_v  = '{32'h0, 32'h0000_0400, 32'h0000_0BFF, 32'h7FFF_FFFF};
      exp_v  = '{5'd15, 5'd15, 5'd15, 5'd31};
      want_v = '{16'h0000, 16'h3C00, 16'h4200, 16'h7C00};
      fire();
      drain(100, -1, 0, 0, cyc);

      acc_v = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF9000};
      exp_v = '{5'd31, 5'd1, 5'd1, 5'd15};
`ifdef SYSTOLIC_DRAIN_SUBNORM_EN
      want_v = '{16'hFC00, 16'h0001, 16'h8001, 16'hCF00};
`else
      want_v = '{16'hFC00, 16'h0000, 16'h8000, 16'hCF00};
`endif
      fire();
      drain(100, -1, 0, 0, cyc);
      check_eq("pre_missed", 32'(missed), 32'd0);

      // done while busy at index 2 is ignored and flagged.
      randomize_load();
      fire();
      drain(70, -1, 1, 0, cyc);
      check_eq("missed_set", 32'(missed), 32'd1);

      // done on the final transfer restarts immediately.
      randomize_load();
      fire();
      drain(100, -1, 0, 1, cyc);

      // Asynchronous reset between edges mid-drain.
      check_eq("pre_rst_missed", 32'(missed), 32'd1);
      randomize_load();
      fire();
      out_if.out_ready = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check_eq("arst_valid", 32'(out_if.out_valid), 32'd0);
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_missed", 32'(missed), 32'd0);
      check_eq("arst_last", 32'(out_if.out_last), 32'd0);
      #3;
      rst = 1'b0;
      exp_data_q.delete();
      exp_idx_q.delete();
      out_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("post_rst_valid", 32'(out_if.out_valid), 32'd0);
      check_eq("post_rst_busy", 32'(busy), 32'd0);

      // Randomized drains under random backpressure.
      for (int r = 0; r < 30; r++) begin
         randomize_load();
         fire();
         drain(60, -1, 0, 0, cyc);
      end
      check_eq("final_missed", 32'(missed), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Output drain for the FP-INT systolic array. On the array's `done` pulse it snapshots all N*N per-PE accumulators (32-bit two's-complement fixed point plus 5-bit exponent).
- It converts each entry to IEEE FP16 and streams the results out row-major over a valid/ready interface.
- It is the reader/back-end counterpart to the activation/weight feed side of the array.

Parameters:
- N, 2, array dimension; N*N results per drain.
- ACC_WIDTH, 32, accumulator width per PE.
- FRAC_BITS, 10, fractional bits of the accumulator at exponent bias.
- IDX_W, max(1,$clog2(N*N)), result index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- done  in  1  array completion; sampled high on a clock edge = capture request.
- acc_in  in  N*N*ACC_WIDTH  flattened accumulators; entry i = bits [i*ACC_WIDTH +: ACC_WIDTH]; i = row*N+col.
- exp_in  in  N*N*5  flattened exponents; entry i = bits [i*5 +: 5].
- out_valid  out  1  out_data/out_idx/out_last valid.
- out_ready  in  1  consumer accepts when high with out_valid.
- out_data  out  16  FP16 result.
- out_idx  out  IDX_W  index of the current result.
- out_last  out  1  high with the final index N*N-1.
- busy  out  1  snapshot held; drain in progress.
- missed  out  1  sticky; a done arrived while busy. Cleared only by rst.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, missed=0, state IDLE, snapshot cleared.
- States:
  - IDLE: on an edge with done=1, capture all acc_in/exp_in into the snapshot, set idx=0 and go to SEND.
  - SEND: register the conversion of snapshot[idx] into out_data; hold out_valid=1.
- Latency: the done edge is k; out_valid=1 with element 0 after edge k+1.
- Handshake:
  - A transfer occurs on an edge where out_valid & out_ready.
  - On a transfer, the next element is loaded at the same edge, giving 1 result/cycle under ready=1.
  - While out_ready=0, out_data, out_idx and out_last are held stable.
  - out_valid never drops before a transfer.
- After the transfer of idx N*N-1: out_valid=0, busy=0, return to IDLE.
- done in the same cycle as the last transfer is accepted as a new capture; out_valid is reasserted the next cycle.
- done while busy (other cycles) is ignored, the snapshot is unchanged, and missed is set to 1.
- busy=1 from the capture edge until the last transfer edge.
- Conversion, per entry (acc a, exp e):
  - sign = a[MSB]; mag = |a| as an unsigned ACC_WIDTH value, so 0x80000000 gives mag 2^31.
  - a=0 gives 0x0000.
  - p = position of the leading one of mag.
  - Biased FP16 exponent E = p + e − FRAC_BITS, computed signed on 8 bits.
  - Mantissa = the 10 bits below the leading one (zero-extended when p<10), rounded to nearest even using guard and sticky bits.
  - A mantissa carry-out gives mant=0 and E+1.
  - E>=31 gives sign|0x7C00 (infinity).
  - E<=0 is handled per the optional feature below.

Optional Feature:
- Macro SYSTOLIC_DRAIN_SUBNORM_EN.
- Defined: E<=0 produces an FP16 subnormal. The shifted mantissa uses RNE; rounding into the normal range yields E=1. Values below half the smallest subnormal give signed zero.
- Undefined: E<=0 is flushed to signed zero (sign<<15).

Decomposition:
- Package systolic_pkg holds:
  - FP16 constants: EXP_W=5, MANT_W=10, EXP_BIAS=15, FP16_INF=16'h7C00.
  - Drain state enum {IDLE, SEND}.
  - The IDX_W computation function.
- Sub-module fp16_from_fixed: purely combinational (acc, exp) → fp16, containing the leading-one detect, rounding and the macro-dependent underflow path. systolic_drain holds the FSM, snapshot, index counter and output register.

Test Plan:
1. N=2, acc {FFFF9000,FFFF9000,FFFFAC00,FFFFAC00}, exp all 15, ready=1 → out_data CF00,CF00,CD40,CD40 on 4 consecutive cycles starting one cycle after done; idx 0..3; out_last only on idx 3; busy low after.
2. Backpressure: same load, ready=0 for 3 cycles at idx 1 → out_data=CF00 and idx=1 stable; no skipped or duplicated index.
3. Values: acc 0 → 0000; acc 00000400 e15 → 3C00; acc 00000BFF e15 → 4200 (RNE tie up); acc 7FFFFFFF e31 → 7C00; acc 80000000 e31 → FC00.
4. Underflow: acc 00000001 e1 → 0000 without macro, 0001 with SYSTOLIC_DRAIN_SUBNORM_EN; acc FFFFFFFF e1 → 8000 / 8001.
5. done pulsed at idx 2 → ignored, missed=1, original data drained; done in the same cycle as the last transfer → new drain starts next cycle with idx 0.
6. rst asserted mid-drain between edges → out_valid, busy and missed drop immediately; after release no output until a new done.
